nibble_sort_rx: RTL and testbench

- Serial receiving end for the nibble-sort datapath.
- Accepts W-bit values one per cycle on a valid/ready stream and insertion-sorts each group of N values as they arrive, one insertion per cycle.
- Presents the completed group as one packed, ascending-sorted word on a valid/ready output.
- Output word layout: slot 0 (smallest) in the low bits, so downstream logic sees the same packing as the parallel 4x4-bit sorter.

---
 rtl/nibble_sort_pkg.sv | 24 ++
 rtl/nibble_sort_rx_if.sv | 34 +++
 rtl/sort_insert_slice.sv | 43 ++++
 rtl/nibble_sort_rx.sv | 101 ++++++++++
 tb/tb_nibble_sort_rx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/nibble_sort_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nibble_sort_pkg                                                    |
// | Shared types, default sizes and packing helper for nibble sorters. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package nibble_sort_pkg;

    localparam int unsigned DEF_N    = 4;
    localparam int unsigned DEF_W    = 4;
    localparam int unsigned DEF_SEQW = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Slot 0 occupies the low bits of a packed group word.
    function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned w);
        return slot * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_sort_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nibble_sort_rx_if                                                  |
// | Input value stream and sorted-group output stream of the receiver. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface nibble_sort_rx_if
    import nibble_sort_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned W    = DEF_W,
    parameter int unsigned SEQW = DEF_SEQW
) ();

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [N*W-1:0]    out_data;
    logic [SEQW-1:0]   out_seq;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_seq
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_seq
    );

endinterface
`default_nettype wire

// File: rtl/sort_insert_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sort_insert_slice                                                  |
// | Combinational single-value stable insertion into a sorted prefix.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sort_insert_slice
    import nibble_sort_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = $clog2(DEF_N + 1)
) (
    input  logic [N*W-1:0] i_slots,
    input  logic [CW-1:0]  i_count,
    input  logic [W-1:0]   i_v,
    output logic [N*W-1:0] o_slots
);

    // w_keep[j]: slot j lies in the sorted prefix before the insertion point.
    // Using <= places a new value after existing equals.
    logic [N-1:0] w_keep;

    for (genvar j = 0; j < N; j++) begin : g_slot
        localparam int unsigned   c_lsb = slot_lsb(j, W);
        localparam logic [CW-1:0] c_idx = CW'(j);

        logic [W-1:0] w_old;
        assign w_old     = i_slots[c_lsb +: W];
        assign w_keep[j] = (c_idx < i_count) && (w_old <= i_v);

        if (j == 0) begin : g_first
            assign o_slots[c_lsb +: W] = w_keep[j] ? w_old : i_v;
        end else begin : g_rest
            localparam int unsigned c_prev = slot_lsb(j - 1, W);
            assign o_slots[c_lsb +: W] =
                ((c_idx > i_count) || w_keep[j]) ? w_old :
                (w_keep[j-1] ? i_v : i_slots[c_prev +: W]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/nibble_sort_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nibble_sort_rx                                                     |
// | Streaming receiver: insertion-sorts groups of N values.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module nibble_sort_rx
    import nibble_sort_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned W    = DEF_W,
    parameter int unsigned SEQW = DEF_SEQW
) (
    input  logic              clk,
    input  logic              rst_n,
    nibble_sort_rx_if.slave   bus
);

    localparam int unsigned   CW     = $clog2(N + 1);
    localparam logic [CW-1:0] c_last = CW'(N - 1);
    localparam logic [CW-1:0] c_full = CW'(N);

    state_e            r_state, w_state_nxt;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic [N*W-1:0]    r_slots, w_slots_nxt;
    logic [SEQW-1:0]   r_seq,   w_seq_nxt;
    logic [N*W-1:0]    w_ins_slots;
    logic [CW-1:0]     w_ins_count;
    logic              w_in_ready;
    logic              w_in_fire;

    assign w_in_ready = (r_state == ST_FILL) || bus.out_ready;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    // On a handoff the incoming value starts a fresh group at slot 0.
    assign w_ins_count = (r_state == ST_HOLD) ? '0 : r_count;

    sort_insert_slice #(
        .N  (N),
        .W  (W),
        .CW (CW)
    ) u_insert (
        .i_slots (r_slots),
        .i_count (w_ins_count),
        .i_v     (bus.in_data),
        .o_slots (w_ins_slots)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_count <= '0;
            r_slots <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_slots <= w_slots_nxt;
            r_seq   <= w_seq_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_slots_nxt = r_slots;
        w_seq_nxt   = r_seq;
        case (r_state)
            ST_FILL: begin
                if (w_in_fire) begin
                    w_slots_nxt = w_ins_slots;
                    if (r_count == c_last) begin
                        w_count_nxt = c_full;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_seq_nxt   = r_seq + SEQW'(1);
                    w_state_nxt = ST_FILL;
                    if (bus.in_valid) begin
                        w_slots_nxt = w_ins_slots;
                        w_count_nxt = CW'(1);
                    end else begin
                        w_count_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_data  = r_slots;
    assign bus.out_seq   = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_nibble_sort_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nibble_sort_rx                                                  |
// | Directed and random stimulus against a queue-based sort model.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_nibble_sort_rx;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 4;
    localparam int unsigned SEQW = 8;

    logic clk;
    logic rst_n;

    nibble_sort_rx_if #(.N(N), .W(W), .SEQW(SEQW)) bus ();

    nibble_sort_rx #(.N(N), .W(W), .SEQW(SEQW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]     cur_q[$];
    logic [N*W-1:0]   exp_q[$];
    logic [SEQW-1:0]  seq_q[$];
    logic [SEQW-1:0]  next_seq;
    int               pops;
    logic [SEQW-1:0]  last_pop_seq;
    logic             have_pop;
    logic             saw_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of model evaluation: sample mid-cycle, then advance past the edge.
    task automatic tick();
        logic         exp_rdy;
        logic [W-1:0] srt[$];
        logic [N*W-1:0] word;
        @(negedge clk);
        exp_rdy = (exp_q.size() == 0) || bus.out_ready;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
            chk("out_seq", 32'(bus.out_seq), 32'(seq_q[0]));
            if (bus.out_ready) begin
                if (have_pop && last_pop_seq == 8'hFF && seq_q[0] == 8'h00) saw_wrap = 1'b1;
                last_pop_seq = seq_q[0];
                have_pop = 1'b1;
                void'(exp_q.pop_front());
                void'(seq_q.pop_front());
                pops++;
            end
        end
        if (bus.in_valid && exp_rdy) begin
            cur_q.push_back(bus.in_data);
            if (cur_q.size() == N) begin
                srt = cur_q;
                srt.sort();
                word = '0;
                for (int i = 0; i < N; i++) word = word | ((N*W)'(srt[i]) << (W * i));
                exp_q.push_back(word);
                seq_q.push_back(next_seq);
                next_seq = next_seq + 8'd1;
                cur_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        cur_q.delete();
        exp_q.delete();
        seq_q.delete();
        next_seq = '0;
        #2;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_seq", 32'(bus.out_seq), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] v, input logic ordy);
        bus.in_valid  = 1'b1;
        bus.in_data   = v;
        bus.out_ready = ordy;
        tick();
    endtask

    task automatic idle(input logic ordy);
        bus.in_valid  = 1'b0;
        bus.out_ready = ordy;
        tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        pops = 0; have_pop = 1'b0; saw_wrap = 1'b0; last_pop_seq = '0;
        @(posedge clk); #1;
        do_reset();

        // Basic group, latency one cycle after the last accept.
        send(4'h3, 1'b1); send(4'h1, 1'b1); send(4'h4, 1'b1); send(4'h2, 1'b1);
        chk("g0_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("g0_data", 32'(bus.out_data), 32'h4321);
        chk("g0_seq", 32'(bus.out_seq), 32'd0);
        idle(1'b1);

        do_reset();
        send(4'hF, 1'b1); send(4'h0, 1'b1); send(4'hF, 1'b1); send(4'h0, 1'b1);
        chk("g_ff00", 32'(bus.out_data), 32'hFF00);
        idle(1'b1);
        send(4'h7, 1'b1); send(4'h7, 1'b1); send(4'h7, 1'b1); send(4'h7, 1'b1);
        chk("g_7777", 32'(bus.out_data), 32'h7777);
        chk("g_7777_seq", 32'(bus.out_seq), 32'd1);
        idle(1'b1);

        // Backpressure with a pending value, then simultaneous handoff.
        send(4'h5, 1'b0); send(4'hA, 1'b0); send(4'h1, 1'b0); send(4'hC, 1'b0);
        for (int i = 0; i < 5; i++) send(4'h6, 1'b0);
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_data", 32'(bus.out_data), 32'hCA51);
        send(4'h6, 1'b1);
        chk("handoff_valid", {31'd0, bus.out_valid}, 32'd0);
        send(4'h2, 1'b1); send(4'h8, 1'b1); send(4'h0, 1'b1);
        chk("handoff_group", 32'(bus.out_data), 32'h8620);
        chk("handoff_seq", 32'(bus.out_seq), 32'd3);

        // Continuous stream: no bubble expected on in_ready.
        for (int i = 0; i < 12; i++) send(4'h9 - 4'(i % 4), 1'b1);
        idle(1'b1);

        // Reset mid-group discards earlier values.
        send(4'h5, 1'b1); send(4'h2, 1'b1);
        do_reset();
        send(4'hA, 1'b1); send(4'hB, 1'b1); send(4'hC, 1'b1); send(4'hD, 1'b1);
        chk("post_rst_data", 32'(bus.out_data), 32'hDCBA);
        chk("post_rst_seq", 32'(bus.out_seq), 32'd0);
        idle(1'b1);

        // Random traffic through a full sequence-counter wrap.
        do_reset();
        pops = 0; have_pop = 1'b0; saw_wrap = 1'b0;
        for (int it = 0; it < 20000 && pops < 257; it++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = W'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        chk("rand_groups", 32'(pops), 32'd257);
        chk("seq_wrap", {31'd0, saw_wrap}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
